// File: rtl/int_ctrl.sv
// int_ctrl: six-source interrupt controller on the system bridge.
// Each source is latched in edge or level mode, masked onto hwint, and the
// lowest-index pending+enabled source is reported through the ID register.
// Edge sources get a holdoff window after acknowledge; rises during that
// window are remembered and delivered when the window closes.
module int_ctrl #(
  parameter logic [31:0] BASE    = 32'h0000_7f20,
  parameter int unsigned HOLDOFF = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  src_irq,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  output logic [31:0] rdata,
  output logic [5:0]  hwint,
  output logic        irq
);

  localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF);

  // The holdoff counter is only 4 bits wide, so larger values cannot be honoured
  if (HOLDOFF > 15) begin : g_bad_holdoff
    $error("int_ctrl: HOLDOFF must be in 0..15");
  end

  logic [5:0]      pend_q, pend_d;
  logic [5:0]      mask_q, mask_d;
  logic [5:0]      mode_q, mode_d;
  logic [5:0]      defer_q, defer_d;
  logic [5:0][3:0] hold_q, hold_d;
  logic [5:0]      src_q, src_d;

  logic       win_sel;
  logic       bus_wr;
  logic       state_wr;
  logic [1:0] reg_off;
  logic [5:0] ack, rise, busy, expire, set_now, mode_chg;
  logic [2:0] irq_id;
  logic       unused_bits;

  assign win_sel     = (addr & ~32'hf) == BASE;
  assign bus_wr      = win_sel & (|byteen);
  assign state_wr    = bus_wr & byteen[0];
  assign reg_off     = addr[3:2];
  assign unused_bits = ^{addr[1:0], wdata[31:6]};

  // Config registers written from the bus; source lines sampled every cycle
  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    src_d  = src_irq;
    if (state_wr && reg_off == 2'd1) mask_d = wdata[5:0];
    if (state_wr && reg_off == 2'd2) mode_d = wdata[5:0];
  end

  // Per-source events: acknowledge, rising edge, holdoff state and what sets pend
  always_comb begin
    ack      = (state_wr && reg_off == 2'd0) ? wdata[5:0] : 6'd0;
    rise     = src_irq & ~src_q;
    mode_chg = mode_d ^ mode_q;
    busy     = '0;
    expire   = '0;
    for (int i = 0; i < 6; i++) begin
      busy[i]   = hold_q[i] != 4'd0;
      expire[i] = hold_q[i] == 4'd1;
    end
    set_now = (expire & (defer_q | rise)) | (rise & ~busy);
  end

  // Next pend/defer/holdoff per source; a mode change wipes that source clean
  always_comb begin
    pend_d  = pend_q;
    defer_d = defer_q;
    hold_d  = hold_q;
    for (int i = 0; i < 6; i++) begin
      if (mode_chg[i]) begin
        pend_d[i]  = 1'b0;
        defer_d[i] = 1'b0;
        hold_d[i]  = 4'd0;
      end else if (mode_q[i]) begin
        pend_d[i]  = set_now[i] | (pend_q[i] & ~ack[i]);
        defer_d[i] = ~expire[i] & (defer_q[i] | (rise[i] & busy[i]));
        if (ack[i]) begin
          hold_d[i] = HOLD_LOAD;
        end else if (busy[i]) begin
          hold_d[i] = hold_q[i] - 4'd1;
        end
      end else begin
        pend_d[i]  = src_irq[i];
        defer_d[i] = 1'b0;
        hold_d[i]  = 4'd0;
      end
    end
  end

  assign hwint = pend_q & mask_q;
  assign irq   = |hwint;

  // Lowest-index enabled pending source wins; 7 means nothing pending
  always_comb begin
    irq_id = 3'd7;
    for (int i = 5; i >= 0; i--) begin
      if (hwint[i]) irq_id = 3'(i);
    end
  end

  // Combinational read mux, zero outside the register window
  always_comb begin
    rdata = '0;
    if (win_sel) begin
      case (reg_off)
        2'd0: rdata = {26'd0, pend_q};
        2'd1: rdata = {26'd0, mask_q};
        2'd2: rdata = {26'd0, mode_q};
        2'd3: rdata = {29'd0, irq_id};
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q  <= '0;
      mask_q  <= '0;
      mode_q  <= '0;
      defer_q <= '0;
      hold_q  <= '0;
      src_q   <= '0;
    end else begin
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      defer_q <= defer_d;
      hold_q  <= hold_d;
      src_q   <= src_d;
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed scenarios plus a randomized run for int_ctrl.
// Two instances share all inputs: dut_a with HOLDOFF=4, dut_b with HOLDOFF=0.
// The reference model tracks holdoff as an absolute release edge number
// per source rather than as a countdown.
module tb_int_ctrl;

  localparam logic [31:0] BASE = 32'h0000_7f20;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  src_irq;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byteen;
  logic [31:0] rdata_a, rdata_b;
  logic [5:0]  hwint_a, hwint_b;
  logic        irq_a, irq_b;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  int_ctrl #(.BASE(BASE), .HOLDOFF(4)) dut_a (
    .clk(clk), .reset(reset), .src_irq(src_irq), .addr(addr), .wdata(wdata),
    .byteen(byteen), .rdata(rdata_a), .hwint(hwint_a), .irq(irq_a)
  );

  int_ctrl #(.BASE(BASE), .HOLDOFF(0)) dut_b (
    .clk(clk), .reset(reset), .src_irq(src_irq), .addr(addr), .wdata(wdata),
    .byteen(byteen), .rdata(rdata_b), .hwint(hwint_b), .irq(irq_b)
  );

  // Reference model state, index 0 models dut_a and index 1 models dut_b
  logic [5:0] m_pend  [2];
  logic [5:0] m_mask  [2];
  logic [5:0] m_mode  [2];
  logic [5:0] m_defer [2];
  int         m_release [2][6];
  logic [5:0] m_src_prev;
  int         edge_no = 0;

  function automatic int hold_of(int h);
    return (h == 0) ? 4 : 0;
  endfunction

  // Model: a rise before a source's release edge is deferred, delivered on that edge
  always @(posedge clk) begin : ref_model
    logic       wr;
    logic [1:0] off;
    logic [5:0] new_mode;
    bit         rise, ack, expiring, fired;
    edge_no++;
    wr  = ((addr & ~32'hf) == BASE) && byteen[0];
    off = addr[3:2];
    for (int h = 0; h < 2; h++) begin
      if (reset) begin
        m_pend[h] = '0; m_mask[h] = '0; m_mode[h] = '0; m_defer[h] = '0;
        for (int i = 0; i < 6; i++) m_release[h][i] = 0;
      end else begin
        new_mode = (wr && off == 2'd2) ? wdata[5:0] : m_mode[h];
        for (int i = 0; i < 6; i++) begin
          if (m_mode[h][i]) begin
            rise     = src_irq[i] && !m_src_prev[i];
            ack      = wr && off == 2'd0 && wdata[i];
            expiring = hold_of(h) > 0 && edge_no == m_release[h][i];
            fired    = expiring ? (m_defer[h][i] || rise) : (rise && edge_no >= m_release[h][i]);
            if (expiring) m_defer[h][i] = 1'b0;
            else if (rise && !fired) m_defer[h][i] = 1'b1;
            if (fired) m_pend[h][i] = 1'b1;
            else if (ack) m_pend[h][i] = 1'b0;
            if (ack) m_release[h][i] = edge_no + hold_of(h);
          end else begin
            m_pend[h][i]    = src_irq[i];
            m_defer[h][i]   = 1'b0;
            m_release[h][i] = 0;
          end
          if (new_mode[i] != m_mode[h][i]) begin
            m_pend[h][i]    = 1'b0;
            m_defer[h][i]   = 1'b0;
            m_release[h][i] = 0;
          end
        end
        if (wr && off == 2'd1) m_mask[h] = wdata[5:0];
        m_mode[h] = new_mode;
      end
    end
    m_src_prev = reset ? 6'd0 : src_irq;
  end

  function automatic logic [5:0] exp_hwint(int h);
    return m_pend[h] & m_mask[h];
  endfunction

  function automatic logic [31:0] exp_rdata(int h, logic [31:0] a);
    logic [5:0] hw;
    hw = m_pend[h] & m_mask[h];
    if ((a & ~32'hf) != BASE) return 32'd0;
    case (a[3:2])
      2'd0: return {26'd0, m_pend[h]};
      2'd1: return {26'd0, m_mask[h]};
      2'd2: return {26'd0, m_mode[h]};
      default: begin
        for (int i = 0; i < 6; i++) if (hw[i]) return 32'(i);
        return 32'd7;
      end
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [3:0] off, input logic [31:0] val);
    addr   = BASE + {28'd0, off};
    wdata  = val;
    byteen = 4'b0001;
    cyc();
    byteen = 4'b0000;
    addr   = 32'd0;
    wdata  = 32'd0;
  endtask

  task automatic bus_point(input logic [31:0] a);
    addr = a;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; src_irq = 6'h3f; addr = 32'd0; wdata = 32'd0; byteen = 4'b0000;
    cyc(); cyc();
    total++; if (hwint_a !== 6'h00) $display("[TB] FAIL reset_hwint got %h want %h", hwint_a, 6'h00); else passed++;
    total++; if (irq_a !== 1'b0) $display("[TB] FAIL reset_irq got %b want %b", irq_a, 1'b0); else passed++;
    bus_point(BASE + 32'hc);
    total++; if (rdata_a !== 32'd7) $display("[TB] FAIL reset_id got %h want %h", rdata_a, 32'd7); else passed++;
    bus_point(BASE);
    total++; if (rdata_a !== 32'd0) $display("[TB] FAIL reset_pend got %h want %h", rdata_a, 32'd0); else passed++;
    bus_point(BASE + 32'h4);
    total++; if (rdata_a !== 32'd0) $display("[TB] FAIL reset_mask got %h want %h", rdata_a, 32'd0); else passed++;
    bus_point(BASE + 32'h8);
    total++; if (rdata_b !== 32'd0) $display("[TB] FAIL reset_mode got %h want %h", rdata_b, 32'd0); else passed++;
    reset = 1'b0; addr = 32'd0;
    cyc();
    bus_point(BASE);
    total++; if (rdata_a !== 32'h3f) $display("[TB] FAIL post_reset_pend got %h want %h", rdata_a, 32'h3f); else passed++;
    total++; if (hwint_a !== 6'h00) $display("[TB] FAIL post_reset_masked got %h want %h", hwint_a, 6'h00); else passed++;
    bus_point(BASE + 32'h10);
    total++; if (rdata_a !== 32'd0) $display("[TB] FAIL out_of_window got %h want %h", rdata_a, 32'd0); else passed++;
    src_irq = 6'h00; addr = 32'd0;
    cyc();
  endtask

  task automatic test_edge_ack();
    bus_write(4'h8, 32'h3f);
    bus_write(4'h4, 32'h3f);
    src_irq = 6'h04;
    cyc();
    total++; if (hwint_a !== 6'h04) $display("[TB] FAIL edge_set got %h want %h", hwint_a, 6'h04); else passed++;
    total++; if (irq_a !== 1'b1) $display("[TB] FAIL edge_irq got %b want %b", irq_a, 1'b1); else passed++;
    src_irq = 6'h00;
    bus_point(BASE + 32'hc);
    total++; if (rdata_a !== 32'd2) $display("[TB] FAIL edge_id got %h want %h", rdata_a, 32'd2); else passed++;
    bus_write(4'h0, 32'h04);
    total++; if (hwint_a !== 6'h00) $display("[TB] FAIL ack_clear_a got %h want %h", hwint_a, 6'h00); else passed++;
    total++; if (hwint_b !== 6'h00) $display("[TB] FAIL ack_clear_b got %h want %h", hwint_b, 6'h00); else passed++;
  endtask

  // Runs directly after the acknowledge in test_edge_ack
  task automatic test_holdoff();
    cyc();
    src_irq = 6'h04;
    cyc();
    total++; if (hwint_a !== 6'h00) $display("[TB] FAIL holdoff_deferred got %h want %h", hwint_a, 6'h00); else passed++;
    total++; if (hwint_b !== 6'h04) $display("[TB] FAIL holdoff0_immediate got %h want %h", hwint_b, 6'h04); else passed++;
    src_irq = 6'h00;
    cyc();
    total++; if (hwint_a !== 6'h00) $display("[TB] FAIL holdoff_k3 got %h want %h", hwint_a, 6'h00); else passed++;
    cyc();
    total++; if (hwint_a !== 6'h04) $display("[TB] FAIL holdoff_release got %h want %h", hwint_a, 6'h04); else passed++;
    bus_write(4'h0, 32'h04);
    repeat (5) cyc();
  endtask

  task automatic test_simultaneous();
    src_irq = 6'h08;
    bus_write(4'h0, 32'h08);
    total++; if (hwint_a !== 6'h08) $display("[TB] FAIL simul_hwint_a got %h want %h", hwint_a, 6'h08); else passed++;
    total++; if (hwint_b !== 6'h08) $display("[TB] FAIL simul_hwint_b got %h want %h", hwint_b, 6'h08); else passed++;
    bus_point(BASE);
    total++; if (rdata_a !== 32'h08) $display("[TB] FAIL simul_pend got %h want %h", rdata_a, 32'h08); else passed++;
    src_irq = 6'h00;
    bus_write(4'h0, 32'h08);
    total++; if (hwint_a !== 6'h00) $display("[TB] FAIL simul_cleanup got %h want %h", hwint_a, 6'h00); else passed++;
    repeat (5) cyc();
  endtask

  task automatic test_level_mask();
    bus_write(4'h8, 32'h00);
    bus_write(4'h4, 32'h01);
    total++; if (hwint_a !== 6'h00) $display("[TB] FAIL level_idle got %h want %h", hwint_a, 6'h00); else passed++;
    src_irq = 6'h01;
    for (int j = 0; j < 5; j++) begin
      if (j == 2) bus_write(4'h0, 32'h01);
      else cyc();
      total++; if (hwint_a !== 6'h01) $display("[TB] FAIL level_follow cycle %0d got %h want %h", j, hwint_a, 6'h01); else passed++;
    end
    src_irq = 6'h00;
    cyc();
    total++; if (hwint_a !== 6'h00) $display("[TB] FAIL level_drop got %h want %h", hwint_a, 6'h00); else passed++;
    src_irq = 6'h02;
    cyc();
    total++; if (hwint_a !== 6'h00) $display("[TB] FAIL level_masked got %h want %h", hwint_a, 6'h00); else passed++;
    bus_point(BASE);
    total++; if (rdata_a !== 32'h02) $display("[TB] FAIL level_pend got %h want %h", rdata_a, 32'h02); else passed++;
    src_irq = 6'h00; addr = 32'd0;
    cyc();
  endtask

  task automatic test_priority();
    bus_write(4'h8, 32'h3f);
    bus_write(4'h4, 32'h3f);
    src_irq = 6'h12;
    cyc();
    src_irq = 6'h00;
    bus_point(BASE + 32'hc);
    total++; if (rdata_a !== 32'd1) $display("[TB] FAIL prio_id1 got %h want %h", rdata_a, 32'd1); else passed++;
    bus_write(4'h4, 32'h3d);
    bus_point(BASE + 32'hc);
    total++; if (rdata_a !== 32'd4) $display("[TB] FAIL prio_id4 got %h want %h", rdata_a, 32'd4); else passed++;
    bus_write(4'h0, 32'h12);
    bus_point(BASE + 32'hc);
    total++; if (rdata_a !== 32'd7) $display("[TB] FAIL prio_id7 got %h want %h", rdata_a, 32'd7); else passed++;
    total++; if (hwint_a !== 6'h00) $display("[TB] FAIL prio_hwint got %h want %h", hwint_a, 6'h00); else passed++;
    addr = 32'd0;
    repeat (5) cyc();
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 800; n++) begin
      reset = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 1) == 0) src_irq = src_irq ^ 6'($urandom);
      r = $urandom_range(0, 9);
      if (r < 2) begin
        addr = BASE + 32'($urandom_range(0, 1) * 4);
        wdata = $urandom; byteen = 4'($urandom_range(1, 15));
      end else if (r < 4) begin
        addr = BASE + 32'($urandom_range(2, 3) * 4);
        wdata = (r == 2) ? {$urandom, 4'h0} & 32'h0000_00f0 | {26'd0, 6'($urandom_range(60, 63))} : $urandom;
        byteen = 4'($urandom_range(1, 15));
      end else if (r == 4) begin
        addr = $urandom; wdata = $urandom; byteen = 4'($urandom_range(1, 15));
      end else begin
        addr = 32'd0; wdata = 32'd0; byteen = 4'b0000;
      end
      cyc();
      total++; if (hwint_a !== exp_hwint(0)) $display("[TB] FAIL rand_hwint_a cycle %0d got %h want %h", n, hwint_a, exp_hwint(0)); else passed++;
      total++; if (hwint_b !== exp_hwint(1)) $display("[TB] FAIL rand_hwint_b cycle %0d got %h want %h", n, hwint_b, exp_hwint(1)); else passed++;
      total++; if (irq_a !== (|exp_hwint(0))) $display("[TB] FAIL rand_irq_a cycle %0d got %b want %b", n, irq_a, |exp_hwint(0)); else passed++;
      byteen = 4'b0000; wdata = 32'd0;
      bus_point(BASE + 32'($urandom_range(0, 4) * 4));
      total++; if (rdata_a !== exp_rdata(0, addr)) $display("[TB] FAIL rand_rdata_a cycle %0d addr %h got %h want %h", n, addr, rdata_a, exp_rdata(0, addr)); else passed++;
      total++; if (rdata_b !== exp_rdata(1, addr)) $display("[TB] FAIL rand_rdata_b cycle %0d addr %h got %h want %h", n, addr, rdata_b, exp_rdata(1, addr)); else passed++;
    end
    reset = 1'b0; addr = 32'd0;
  endtask

  initial begin
    test_reset();
    test_edge_ack();
    test_holdoff();
    test_simultaneous();
    test_level_mask();
    test_priority();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Interrupt controller between the external and timer interrupt sources and the CPU's `HWInt[5:0]` inputs. It latches up to six requests in edge or level mode, applies a mask, and reports the lowest-index pending source through an ID register. It also enforces a per-source holdoff after acknowledge. It is a memory-mapped peripheral on the system bridge at word addresses 0x7f20–0x7f2c; the CPU acknowledges requests by writing to 0x7f20.

## Interface
- `BASE`, default 32'h0000_7f20: base byte address of the 16-byte register window.
- `HOLDOFF`, default 4: cycles after an acknowledge during which new edges on that source are deferred. Range 0–15; 0 disables the holdoff.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `src_irq` in 6: raw request lines; bit i = source i.
- `addr` in 32: bridge byte address.
- `wdata` in 32: write data.
- `byteen` in 4: byte write enables; any set bit marks a write.
- `rdata` out 32: combinational read data for `addr`; 0 when the window is not selected.
- `hwint` out 6: `pend & mask`, driven from registers only.
- `irq` out 1: `|hwint`.

## Operation
- Window select: `(addr & ~32'hf) == BASE`.
- Write: occurs when the window is selected and `|byteen`. Only `byteen[0]` affects state; all registers are 6-bit in bits [5:0], and upper bits read 0.
- Registers, by offset:
  - 0x0 PEND: read gives pending. Write is write-1-to-clear, applied to edge-mode bits only.
  - 0x4 MASK: read/write.
  - 0x8 MODE: read/write. Bit 1 = edge, bit 0 = level.
  - 0xC ID: read-only. Returns the index of the lowest set bit of `pend & mask`, or 7 if none. Writes are ignored.
- Internal state: `src_q[5:0]`, the previous-cycle sample of `src_irq`.
- Edge mode, bit i:
  - `rise_i = src_irq[i] & ~src_q[i]`.
  - If `hold_cnt[i] == 0`, a rise sets `pend[i]`.
  - Otherwise the rise sets `defer[i]`.
- Level mode, bit i:
  - `pend[i] <= src_irq[i]` every cycle.
  - W1C, holdoff and defer have no effect.
- Acknowledge (edge bit i):
  - A W1C with bit i set clears `pend[i]`.
  - It loads `hold_cnt[i] = HOLDOFF`.
- Holdoff countdown:
  - `hold_cnt[i]` decrements each cycle while nonzero.
  - On the cycle it goes 1 → 0: if `defer[i]` is set, `pend[i]` is set and `defer[i]` is cleared.
- Set and clear on the same edge, same bit: the set wins. `pend` stays 1, and `hold_cnt` is still loaded.
- MODE write: for every bit whose mode changes, `pend`, `defer` and `hold_cnt` are cleared on that edge.
- Width rules:
  - `hold_cnt` is 4 bits.
  - `HOLDOFF > 15` is a configuration error.
  - ID is 3 bits, zero-extended on `rdata`.

## Timing
- Reset, synchronous, active-high. On the edge where `reset` is sampled high:
  - `pend`, `mask`, `mode`, `defer`, `hold_cnt` and `src_q` all go to 0.
  - Therefore `hwint = 0`, `irq = 0`, and ID reads 7.
  - Reset takes precedence over any simultaneous bus write or source edge.
  - Reset mid-holdoff discards deferred requests.
- Source to `hwint` latency: 1 cycle. A rise present before edge k appears on `hwint` right after edge k, in both modes.
- Register write effect: visible on `hwint` and `rdata` right after the write edge.
  - A MASK write at edge k gates `hwint` from k onward.
  - A W1C at edge k drops `hwint[i]` after k.
- `rdata` is combinational from current registers; a write at edge k reads back new data after k.
- Holdoff example: W1C at edge k with `HOLDOFF = 4` gives `hold_cnt = 4, 3, 2, 1, 0` after edges k..k+4.
  - A rise during that window makes the deferred `pend` appear after edge k+4.
  - A rise at edge k+4 or later sets `pend` normally.
- A rise that lands on a masked bit still sets `pend`. `hwint` asserts on a later MASK enable with no further source activity.

## Test plan
- Reset: hold `reset` 2 cycles while `src_irq = 6'h3F`. Required: `hwint = 0`, `irq = 0`, ID = 7, PEND/MASK/MODE read 0; first source sampling occurs after release.
- Edge set/ack: MODE = 0x3F, MASK = 0x3F; 1-cycle pulse on `src_irq[2]`. Required: `hwint = 6'h04` one cycle later, ID = 2. Write 0x04 to 0x7f20 with `byteen = 4'b0001`. Required: `hwint = 0` after that edge.
- Holdoff/defer: as above, then pulse `src_irq[2]` 2 cycles after the ack. Required: `hwint[2]` reasserts exactly 4 cycles after the ack edge. Repeat with `HOLDOFF = 0`. Required: reassert 1 cycle after the pulse.
- Simultaneous set/clear: rise on `src_irq[3]` on the same edge as a W1C of 0x08. Required: `pend[3]` stays 1 and `hwint[3]` stays 1.
- Level mode/mask: MODE = 0, MASK = 0x01; hold `src_irq[0]` high 5 cycles, then low.
  - Required: `hwint[0]` follows with 1-cycle lag.
  - A W1C of 0x01 while high has no effect.
  - `src_irq[1]` high gives `hwint[1] = 0`, while PEND bit 1 reads 1.
- Priority/ID: MODE = 0x3F, MASK = 0x3F; pulse sources 1 and 4 together. Required: ID = 1. Clear MASK bit 1. Required: ID = 4. Ack both. Required: ID = 7.
